// File: rtl/sd_emmc_fifo_filler_pkg.sv
// Shared constants for the eMMC FIFO filler: default depth, err_flags bit
// positions and the AXI-side byte-swap helper.
package sd_emmc_fifo_filler_pkg;

  localparam int FIFO_ADDR_W = 7;
  localparam int FIFO_DATA_W = 32;

  localparam int ERR_RX_OVERFLOW  = 0;
  localparam int ERR_RX_UNDERFLOW = 1;
  localparam int ERR_TX_OVERFLOW  = 2;
  localparam int ERR_TX_UNDERFLOW = 3;

  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sd_emmc_sync_fifo.sv
// Single-clock FWFT FIFO. It holds the pointers, occupancy count and storage,
// and emits single-cycle overflow/underflow strobes for rejected accesses.
module sd_emmc_sync_fifo #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   count_q;
  logic              push_ok;
  logic              pop_ok;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A full FIFO still takes a push when the same-cycle pop frees a slot.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop_ok);
  assign overflow  = push && !push_ok;
  assign underflow = pop && empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset so it maps onto a plain dual-port RAM; the
  // count alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (reset && !clear && push_ok) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sd_emmc_fifo_filler.sv
// RX/TX word buffers between the eMMC data-serial engine and the DMA master,
// with optional AXI-side byte swapping and sticky error flags.
module sd_emmc_fifo_filler
  import sd_emmc_fifo_filler_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int BYTE_SWAP = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            fifo_rst,
  input  logic            fifo_dat_rd_ready,
  output logic [31:0]     axi_wdata,
  input  logic            fifo_dat_wr_ready,
  input  logic [31:0]     axi_rdata,
  input  logic            sd_rx_we,
  input  logic [31:0]     sd_rx_data,
  output logic            sd_rx_full,
  input  logic            sd_tx_rd,
  output logic [31:0]     sd_tx_data,
  output logic            sd_tx_empty,
  output logic [ADDR_W:0] rx_count,
  output logic [ADDR_W:0] tx_count,
  output logic [3:0]      err_flags,
  input  logic            err_clr
);

  logic [31:0] rx_head;
  logic [31:0] tx_push_data;
  logic        rx_empty_unused;
  logic        tx_full_unused;
  logic        rx_overflow, rx_underflow, tx_overflow, tx_underflow;
  logic [3:0]  err_set;

  // Swapping happens only on the AXI side, so the serial engine always sees
  // card byte order.
  assign axi_wdata    = (BYTE_SWAP != 0) ? byte_swap32(rx_head) : rx_head;
  assign tx_push_data = (BYTE_SWAP != 0) ? byte_swap32(axi_rdata) : axi_rdata;

  sd_emmc_sync_fifo #(.ADDR_W(ADDR_W), .DATA_W(FIFO_DATA_W)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_rst),
    .push      (sd_rx_we),
    .push_data (sd_rx_data),
    .pop       (fifo_dat_rd_ready),
    .pop_data  (rx_head),
    .full      (sd_rx_full),
    .empty     (rx_empty_unused),
    .count     (rx_count),
    .overflow  (rx_overflow),
    .underflow (rx_underflow)
  );

  sd_emmc_sync_fifo #(.ADDR_W(ADDR_W), .DATA_W(FIFO_DATA_W)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (fifo_rst),
    .push      (fifo_dat_wr_ready),
    .push_data (tx_push_data),
    .pop       (sd_tx_rd),
    .pop_data  (sd_tx_data),
    .full      (tx_full_unused),
    .empty     (sd_tx_empty),
    .count     (tx_count),
    .overflow  (tx_overflow),
    .underflow (tx_underflow)
  );

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    err_set                   = '0;
    err_set[ERR_RX_OVERFLOW]  = rx_overflow;
    err_set[ERR_RX_UNDERFLOW] = rx_underflow;
    err_set[ERR_TX_OVERFLOW]  = tx_overflow;
    err_set[ERR_TX_UNDERFLOW] = tx_underflow;
  end

  // A flag raised in the same cycle as err_clr survives the clear.
  always_ff @(posedge clock) begin
    if (!reset || fifo_rst) err_flags <= '0;
    else                    err_flags <= (err_clr ? 4'b0000 : err_flags) | err_set;
  end

endmodule
